biriscv_v_issue: RTL and testbench

- Single-occupancy vector issue/operand stage directly upstream of the vector ALU.
- Accepts one decoded vector arithmetic op per handshake and reads vs2, vs1 and v0 from the vector register file (VRF).
- Builds operand B from vs1, a broadcast scalar rs1, or a sign-extended imm5. Drives the ALU inputs, captures the ALU result and presents it to writeback with a valid/ready handshake.

---
 rtl/biriscv_v_pkg.sv | 26 ++
 rtl/biriscv_v_opb_gen.sv | 36 +++
 rtl/biriscv_v_issue.sv | 153 +++++++++++++++
 tb/tb_biriscv_v_issue.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_v_pkg.sv
// rtl/biriscv_v_pkg.sv - shared state, operand-select and lane-count definitions for the vector issue stage
package biriscv_v_pkg;

   // Issue stage sequencing: accept, VRF read, ALU execute, writeback hold
   typedef enum logic [1:0] {
      V_IDLE = 2'd0,
      V_READ = 2'd1,
      V_EXEC = 2'd2,
      V_WB   = 2'd3
   } v_state_e;

   // Operand B sources; 2'b11 is reserved and decodes as VI
   localparam logic [1:0] VSEL_VV = 2'b00;
   localparam logic [1:0] VSEL_VX = 2'b01;
   localparam logic [1:0] VSEL_VI = 2'b10;

   // Default geometry of the vector unit
   localparam int V_VLEN = 128;
   localparam int V_ELEN = 32;

   // Number of ELEN-wide lanes in one VLEN-wide register
   function automatic int lane_count(input int vlen, input int elen);
      return vlen / elen;
   endfunction

endpackage

// File: rtl/biriscv_v_opb_gen.sv
// rtl/biriscv_v_opb_gen.sv - operand B mux: vs1 data, broadcast scalar or broadcast sign-extended imm5
module biriscv_v_opb_gen
   import biriscv_v_pkg::*;
#(
   parameter int VLEN = V_VLEN,
   parameter int ELEN = V_ELEN
) (
   input  logic [1:0]      sel_i,
   input  logic [VLEN-1:0] vs1_data_i,
   input  logic [ELEN-1:0] rs1_i,
   input  logic [4:0]      imm_i,
   output logic [VLEN-1:0] opb_o
);

   localparam int LANES = lane_count(VLEN, ELEN);

   logic [ELEN-1:0] w_imm_ext;
   logic [VLEN-1:0] w_rs1_bcast;
   logic [VLEN-1:0] w_imm_bcast;

   // imm[4] is the sign bit; every lane sees the same scalar value
   assign w_imm_ext   = {{(ELEN-5){imm_i[4]}}, imm_i};
   assign w_rs1_bcast = {LANES{rs1_i}};
   assign w_imm_bcast = {LANES{w_imm_ext}};

   // Select operand B; the reserved encoding falls through to the immediate form
   always_comb begin
      opb_o = w_imm_bcast;
      case (sel_i)
         VSEL_VV: opb_o = vs1_data_i;
         VSEL_VX: opb_o = w_rs1_bcast;
         default: opb_o = w_imm_bcast;
      endcase
   end

endmodule

// File: rtl/biriscv_v_issue.sv
// rtl/biriscv_v_issue.sv - vector issue/operand stage feeding the vector ALU; BIRISCV_V_ISSUE_WB_OVERLAP_EN lets a new op issue during the WB handshake
module biriscv_v_issue
   import biriscv_v_pkg::*;
#(
   parameter int VLEN   = V_VLEN,
   parameter int ELEN   = V_ELEN,
   parameter int VREG_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              issue_valid_i,
   output logic              issue_ready_o,
   input  logic [3:0]        issue_op_i,
   input  logic [1:0]        issue_sel_i,
   input  logic              issue_vm_i,
   input  logic [VREG_W-1:0] issue_vd_i,
   input  logic [VREG_W-1:0] issue_vs1_i,
   input  logic [VREG_W-1:0] issue_vs2_i,
   input  logic [ELEN-1:0]   issue_rs1_i,
   input  logic [4:0]        issue_imm_i,
   output logic [VREG_W-1:0] vrf_ra0_o,
   output logic [VREG_W-1:0] vrf_ra1_o,
   input  logic [VLEN-1:0]   vrf_rd0_i,
   input  logic [VLEN-1:0]   vrf_rd1_i,
   input  logic [VLEN-1:0]   vrf_v0_i,
   output logic [3:0]        alu_op_o,
   output logic [VLEN-1:0]   alu_a_o,
   output logic [VLEN-1:0]   alu_b_o,
   output logic [VLEN-1:0]   alu_mask_o,
   output logic              alu_vm_o,
   input  logic [VLEN-1:0]   alu_p_i,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [VREG_W-1:0] wb_vd_o,
   output logic [VLEN-1:0]   wb_data_o
);

   v_state_e          r_state;
   v_state_e          w_state_nxt;
   logic              r_rst_done;
   logic [3:0]        r_op;
   logic [1:0]        r_sel;
   logic              r_vm;
   logic [VREG_W-1:0] r_vd;
   logic [VREG_W-1:0] r_vs1;
   logic [VREG_W-1:0] r_vs2;
   logic [ELEN-1:0]   r_rs1;
   logic [4:0]        r_imm;
   logic [VLEN-1:0]   r_wb_data;
   logic [VLEN-1:0]   w_opb;
   logic              w_accept;

   biriscv_v_opb_gen #(
      .VLEN (VLEN),
      .ELEN (ELEN)
   ) u_opb_gen (
      .sel_i      (r_sel),
      .vs1_data_i (vrf_rd1_i),
      .rs1_i      (r_rs1),
      .imm_i      (r_imm),
      .opb_o      (w_opb)
   );

   // Addresses are held from the latched op; the VRF only samples them in READ
   assign vrf_ra0_o = r_vs2;
   assign vrf_ra1_o = r_vs1;
   assign wb_vd_o   = r_vd;
   assign wb_data_o = r_wb_data;
   assign w_accept  = issue_valid_i & issue_ready_o;

   // Next-state and per-state outputs; ALU inputs are quiet except in EXEC
   always_comb begin
      w_state_nxt   = r_state;
      issue_ready_o = 1'b0;
      wb_valid_o    = 1'b0;
      alu_op_o      = '0;
      alu_a_o       = '0;
      alu_b_o       = '0;
      alu_mask_o    = '0;
      alu_vm_o      = 1'b1;
      case (r_state)
         V_IDLE: begin
            // Ready only once a clock has passed with reset released
            issue_ready_o = r_rst_done;
            if (issue_valid_i && r_rst_done) begin
               w_state_nxt = V_READ;
            end
         end
         V_READ: begin
            w_state_nxt = V_EXEC;
         end
         V_EXEC: begin
            alu_op_o    = r_op;
            alu_a_o     = vrf_rd0_i;
            alu_b_o     = w_opb;
            alu_mask_o  = vrf_v0_i;
            alu_vm_o    = r_vm;
            w_state_nxt = V_WB;
         end
         V_WB: begin
            wb_valid_o = 1'b1;
`ifdef BIRISCV_V_ISSUE_WB_OVERLAP_EN
            // Retiring result frees the stage in the same edge
            issue_ready_o = wb_ready_i;
            if (wb_ready_i) begin
               w_state_nxt = issue_valid_i ? V_READ : V_IDLE;
            end
`else
            if (wb_ready_i) begin
               w_state_nxt = V_IDLE;
            end
`endif
         end
         default: begin
            w_state_nxt = V_IDLE;
         end
      endcase
   end

   // State, latched op fields and captured ALU result
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state    <= V_IDLE;
         r_rst_done <= 1'b0;
         r_op       <= '0;
         r_sel      <= '0;
         r_vm       <= 1'b0;
         r_vd       <= '0;
         r_vs1      <= '0;
         r_vs2      <= '0;
         r_rs1      <= '0;
         r_imm      <= '0;
         r_wb_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rst_done <= 1'b1;
         if (w_accept) begin
            r_op  <= issue_op_i;
            r_sel <= issue_sel_i;
            r_vm  <= issue_vm_i;
            r_vd  <= issue_vd_i;
            r_vs1 <= issue_vs1_i;
            r_vs2 <= issue_vs2_i;
            r_rs1 <= issue_rs1_i;
            r_imm <= issue_imm_i;
         end
         if (r_state == V_EXEC) begin
            r_wb_data <= alu_p_i;
         end
      end
   end

endmodule

// File: tb/tb_biriscv_v_issue.sv
// tb/tb_biriscv_v_issue.sv - table-driven scoreboard bench for biriscv_v_issue with VRF and ALU models
`timescale 1ns/1ps
module tb_biriscv_v_issue;

   localparam int VLEN   = 128;
   localparam int ELEN   = 32;
   localparam int VREG_W = 5;
   localparam int LANES  = 4;
   localparam int TMO    = 40;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
`ifdef BIRISCV_V_ISSUE_WB_OVERLAP_EN
   localparam int EXP_GAP = 3;
`else
   localparam int EXP_GAP = 4;
`endif

   localparam logic [127:0] V0 = 128'h00000000_00000001_00000000_00000001;
   localparam logic [127:0] V1 = 128'h00000028_0000001e_00000014_0000000a;
   localparam logic [127:0] V2 = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] V3 = 128'h00000005_00000005_00000005_00000005;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              issue_valid_i;
   logic              issue_ready_o;
   logic [3:0]        issue_op_i;
   logic [1:0]        issue_sel_i;
   logic              issue_vm_i;
   logic [VREG_W-1:0] issue_vd_i, issue_vs1_i, issue_vs2_i;
   logic [ELEN-1:0]   issue_rs1_i;
   logic [4:0]        issue_imm_i;
   logic [VREG_W-1:0] vrf_ra0_o, vrf_ra1_o;
   logic [VLEN-1:0]   vrf_rd0_i, vrf_rd1_i, vrf_v0_i;
   logic [3:0]        alu_op_o;
   logic [VLEN-1:0]   alu_a_o, alu_b_o, alu_mask_o;
   logic              alu_vm_o;
   logic [VLEN-1:0]   alu_p_i;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic [VREG_W-1:0] wb_vd_o;
   logic [VLEN-1:0]   wb_data_o;

   typedef struct {
      logic [3:0]   op;
      logic [1:0]   sel;
      logic         vm;
      logic [4:0]   vd;
      logic [4:0]   vs1;
      logic [4:0]   vs2;
      logic [31:0]  rs1;
      logic [4:0]   imm;
      logic [127:0] exp;
   } vec_t;

   typedef struct packed {
      logic [4:0]   vd;
      logic [127:0] data;
   } sb_t;

   vec_t         tv [7];
   sb_t          sb_q [$];
   sb_t          cur_exp;
   int           acc_cyc [$];
   int           acc_cnt = 0;
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   logic [127:0] vrf [32];

   biriscv_v_issue #(.VLEN(VLEN), .ELEN(ELEN), .VREG_W(VREG_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .issue_valid_i (issue_valid_i),
      .issue_ready_o (issue_ready_o),
      .issue_op_i    (issue_op_i),
      .issue_sel_i   (issue_sel_i),
      .issue_vm_i    (issue_vm_i),
      .issue_vd_i    (issue_vd_i),
      .issue_vs1_i   (issue_vs1_i),
      .issue_vs2_i   (issue_vs2_i),
      .issue_rs1_i   (issue_rs1_i),
      .issue_imm_i   (issue_imm_i),
      .vrf_ra0_o     (vrf_ra0_o),
      .vrf_ra1_o     (vrf_ra1_o),
      .vrf_rd0_i     (vrf_rd0_i),
      .vrf_rd1_i     (vrf_rd1_i),
      .vrf_v0_i      (vrf_v0_i),
      .alu_op_o      (alu_op_o),
      .alu_a_o       (alu_a_o),
      .alu_b_o       (alu_b_o),
      .alu_mask_o    (alu_mask_o),
      .alu_vm_o      (alu_vm_o),
      .alu_p_i       (alu_p_i),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready_i),
      .wb_vd_o       (wb_vd_o),
      .wb_data_o     (wb_data_o)
   );

   initial forever #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Synchronous VRF model with one cycle of read latency
   always @(posedge clk_i) begin
      vrf_rd0_i <= vrf[vrf_ra0_o];
      vrf_rd1_i <= vrf[vrf_ra1_o];
   end
   assign vrf_v0_i = vrf[0];

   // Reference ALU: per-lane add/sub, masked-off lanes produce zero
   always_comb begin
      alu_p_i = '0;
      for (int l = 0; l < LANES; l++) begin
         if (alu_vm_o || alu_mask_o[l*ELEN]) begin
            if (alu_op_o == OP_ADD)
               alu_p_i[l*ELEN +: ELEN] = alu_a_o[l*ELEN +: ELEN] + alu_b_o[l*ELEN +: ELEN];
            else if (alu_op_o == OP_SUB)
               alu_p_i[l*ELEN +: ELEN] = alu_a_o[l*ELEN +: ELEN] - alu_b_o[l*ELEN +: ELEN];
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want event within %0d cycles", name, TMO);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic drive(input vec_t v);
      issue_op_i   = v.op;
      issue_sel_i  = v.sel;
      issue_vm_i   = v.vm;
      issue_vd_i   = v.vd;
      issue_vs1_i  = v.vs1;
      issue_vs2_i  = v.vs2;
      issue_rs1_i  = v.rs1;
      issue_imm_i  = v.imm;
      cur_exp.vd   = v.vd;
      cur_exp.data = v.exp;
   endtask

   // Holds issue_valid until the monitor sees the accept; returns one tick after the accept edge
   task automatic wait_accept(input string name, output logic ok);
      int start;
      int n;
      start = acc_cnt;
      n = 0;
      issue_valid_i = 1'b1;
      while (acc_cnt == start && n < TMO) begin
         tick();
         n++;
      end
      issue_valid_i = 1'b0;
      ok = (acc_cnt != start);
      if (!ok) tmo(name);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   lat;
      logic ok;
      drive(v);
      wait_accept($sformatf("v%0d_accept", idx), ok);
      if (!ok) return;
      lat = 1;
      while (!wb_valid_o && lat < TMO) begin
         tick();
         lat++;
      end
      chk($sformatf("v%0d_latency", idx), lat, 3);
      tick();
      chk($sformatf("v%0d_wb_valid_drop", idx), wb_valid_o, 1'b0);
   endtask

   // Scoreboard: push on accept, pop and compare on writeback handshake
   initial begin
      sb_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i && issue_valid_i && issue_ready_o) begin
            sb_q.push_back(cur_exp);
            acc_cnt++;
            acc_cyc.push_back(cyc);
         end
         if (rst_i && wb_valid_o && sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got wb_valid vd=%0d want no writeback", wb_vd_o);
         end else if (rst_i && wb_valid_o && wb_ready_i) begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data_o, e.data);
            chk("wb_vd", {123'd0, wb_vd_o}, {123'd0, e.vd});
         end
      end
   end

   initial begin
      logic ok;
      int   start;
      int   n;
      int   base;

      tv[0] = '{OP_ADD, 2'b00, 1'b1, 5'd7,  5'd1, 5'd2, 32'h0,        5'h00, 128'h0000002c_00000021_00000016_0000000b};
      tv[1] = '{OP_ADD, 2'b10, 1'b1, 5'd8,  5'd0, 5'd3, 32'h0000dead, 5'h1f, 128'h00000004_00000004_00000004_00000004};
      tv[2] = '{OP_SUB, 2'b01, 1'b0, 5'd9,  5'd1, 5'd2, 32'h00000010, 5'h00, 128'h00000000_fffffff3_00000000_fffffff1};
      tv[3] = '{OP_ADD, 2'b10, 1'b1, 5'd10, 5'd0, 5'd3, 32'h0,        5'h0f, 128'h00000014_00000014_00000014_00000014};
      tv[4] = '{OP_ADD, 2'b11, 1'b1, 5'd31, 5'd0, 5'd3, 32'h0,        5'h10, 128'hfffffff5_fffffff5_fffffff5_fffffff5};
      tv[5] = '{OP_ADD, 2'b01, 1'b1, 5'd1,  5'd0, 5'd1, 32'hffffffff, 5'h03, 128'h00000027_0000001d_00000013_00000009};
      tv[6] = '{OP_SUB, 2'b00, 1'b0, 5'd2,  5'd2, 5'd1, 32'h0,        5'h00, 128'h00000000_0000001b_00000000_00000009};

      for (int r = 0; r < 32; r++) vrf[r] = '0;
      vrf[0] = V0;
      vrf[1] = V1;
      vrf[2] = V2;
      vrf[3] = V3;

      rst_i         = 1'b0;
      issue_valid_i = 1'b0;
      wb_ready_i    = 1'b1;
      drive(tv[0]);
      tick();
      tick();

      chk("rst_ready", issue_ready_o, 1'b0);
      chk("rst_wb_valid", wb_valid_o, 1'b0);
      chk("rst_wb_data", wb_data_o, '0);
      chk("rst_alu_vm", alu_vm_o, 1'b1);
      chk("rst_alu_b", alu_b_o, '0);
      chk("rst_vrf_ra0", vrf_ra0_o, '0);
      rst_i = 1'b1;
      tick();
      chk("rst_ready_after", issue_ready_o, 1'b1);

      for (int i = 0; i < 7; i++) run_vec(tv[i], i);

      // Backpressure: result must hold and a second op must wait for the handshake
      wb_ready_i = 1'b0;
      drive(tv[0]);
      wait_accept("bp_accept", ok);
      drive(tv[1]);
      issue_valid_i = 1'b1;
      start = acc_cnt;
      n = 0;
      while (!wb_valid_o && n < TMO) begin
         tick();
         n++;
      end
      if (!wb_valid_o) tmo("bp_wb_valid");
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d_valid", k), wb_valid_o, 1'b1);
         chk($sformatf("bp%0d_data", k), wb_data_o, tv[0].exp);
         chk($sformatf("bp%0d_vd", k), wb_vd_o, tv[0].vd);
         chk($sformatf("bp%0d_ready", k), issue_ready_o, 1'b0);
         tick();
      end
      chk("bp_no_early_accept", acc_cnt, start);
      wb_ready_i = 1'b1;
      n = 0;
      while (acc_cnt == start && n < TMO) begin
         tick();
         n++;
      end
      issue_valid_i = 1'b0;
      if (acc_cnt == start) tmo("bp_second_accept");
      n = 0;
      while (sb_q.size() != 0 && n < TMO) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) tmo("bp_drain");
      tick();

      // Continuous stream: spacing between accepts
      drive(tv[3]);
      issue_valid_i = 1'b1;
      base = acc_cyc.size();
      n = 0;
      while (acc_cyc.size() < base + 5 && n < 3 * TMO) begin
         tick();
         n++;
      end
      issue_valid_i = 1'b0;
      if (acc_cyc.size() < base + 5) tmo("tput_accepts");
      else
         for (int k = 1; k < 5; k++)
            chk($sformatf("tput_gap%0d", k), acc_cyc[base+k] - acc_cyc[base+k-1], EXP_GAP);
      n = 0;
      while ((sb_q.size() != 0 || wb_valid_o) && n < TMO) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0 || wb_valid_o) tmo("tput_drain");

      // Reset in EXEC discards the op
      drive('{OP_ADD, 2'b01, 1'b0, 5'd5, 5'd1, 5'd2, 32'h12345678, 5'h07, 128'h0});
      wait_accept("rm_accept", ok);
      tick();
      chk("rm_exec_alu_b", alu_b_o, {4{32'h12345678}});
      chk("rm_exec_alu_a", alu_a_o, V2);
      chk("rm_exec_alu_mask", alu_mask_o, V0);
      chk("rm_exec_alu_vm", alu_vm_o, 1'b0);
      chk("rm_exec_alu_op", alu_op_o, OP_ADD);
      rst_i = 1'b0;
      sb_q.delete();
      tick();
      chk("rm_ready", issue_ready_o, 1'b0);
      chk("rm_wb_valid", wb_valid_o, 1'b0);
      chk("rm_wb_data", wb_data_o, '0);
      chk("rm_wb_vd", wb_vd_o, '0);
      chk("rm_alu_a", alu_a_o, '0);
      chk("rm_alu_b", alu_b_o, '0);
      chk("rm_alu_mask", alu_mask_o, '0);
      chk("rm_alu_op", alu_op_o, '0);
      chk("rm_alu_vm", alu_vm_o, 1'b1);
      chk("rm_vrf_ra0", vrf_ra0_o, '0);
      chk("rm_vrf_ra1", vrf_ra1_o, '0);
      rst_i = 1'b1;
      tick();
      chk("rm_ready_after", issue_ready_o, 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rm_quiet%0d", k), wb_valid_o, 1'b0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
